// File: rtl/sequenciador_movimentos.sv
// sequenciador_movimentos: requests a move list over UART, buffers it, then dispatches moves to the executor.
// Optional build macro ECO_MOVIMENTO_EN: echo each stored move byte back over TX.
module sequenciador_movimentos #(
    parameter int PROFUNDIDADE = 32,
    parameter int LOG_PROF     = 5
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       iniciar_i,
    input  logic       rx_pronto_i,
    input  logic [7:0] rx_dados_i,
    output logic       tx_partida_o,
    output logic [7:0] tx_dados_o,
    input  logic       tx_pronto_i,
    output logic       mov_partida_o,
    output logic [2:0] mov_codigo_o,
    input  logic       mov_fim_i,
    output logic       fim_o,
    output logic       erro_o,
    output logic [3:0] db_estado_o
);
    typedef enum logic [3:0] {
        OCIOSO     = 4'd0,
        PEDE       = 4'd1,
        ESPERA_TX  = 4'd2,
        RECEBE     = 4'd3,
        EXECUTA    = 4'd4,
        ESPERA_MOV = 4'd5,
        FIM        = 4'd6
    } estado_t;

    estado_t             estado_q;
    logic [2:0]          mem_q [PROFUNDIDADE];
    logic [LOG_PROF-1:0] wr_q, rd_q;
    logic [LOG_PROF:0]   cont_q;
    logic                tx_partida_q, mov_partida_q, fim_q, erro_q;
    logic [7:0]          tx_dados_q;
    logic [2:0]          mov_codigo_q;
    logic                cheia, vazia, byte_mov, aceita_rx, push, pop;

    assign cheia    = cont_q == (LOG_PROF+1)'(PROFUNDIDADE);
    assign vazia    = cont_q == '0;
    assign byte_mov = rx_dados_i != 8'h00 && rx_dados_i[7:3] == 5'd0;
`ifdef ECO_MOVIMENTO_EN
    // Terminator seen while an echo is still on the wire: stop accepting bytes and wait.
    logic sai_q, eco_pend_q, eco_livre;
    assign eco_livre = !eco_pend_q || tx_pronto_i;
    assign aceita_rx = estado_q == RECEBE && rx_pronto_i && !sai_q;
`else
    assign aceita_rx = estado_q == RECEBE && rx_pronto_i;
`endif
    assign push = aceita_rx && byte_mov && !cheia;
    assign pop  = estado_q == EXECUTA && !vazia;

    assign tx_partida_o  = tx_partida_q;
    assign tx_dados_o    = tx_dados_q;
    assign mov_partida_o = mov_partida_q;
    assign mov_codigo_o  = mov_codigo_q;
    assign fim_o         = fim_q;
    assign erro_o        = erro_q;
    assign db_estado_o   = estado_q;

    // Move storage; left unreset, occupancy is tracked by the pointers and count.
    always_ff @(posedge clock_i) begin
        if (push) mem_q[wr_q] <= rx_dados_i[2:0];
    end

    // Sequencer FSM with FIFO bookkeeping and registered handshake outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            estado_q      <= OCIOSO;
            wr_q          <= '0;
            rd_q          <= '0;
            cont_q        <= '0;
            tx_partida_q  <= 1'b0;
            tx_dados_q    <= 8'h00;
            mov_partida_q <= 1'b0;
            mov_codigo_q  <= 3'd0;
            fim_q         <= 1'b0;
            erro_q        <= 1'b0;
`ifdef ECO_MOVIMENTO_EN
            sai_q         <= 1'b0;
            eco_pend_q    <= 1'b0;
`endif
        end else begin
            tx_partida_q  <= 1'b0;
            mov_partida_q <= 1'b0;
            wr_q          <= wr_q + LOG_PROF'(push);
            rd_q          <= rd_q + LOG_PROF'(pop);
            cont_q        <= cont_q + (LOG_PROF+1)'(push) - (LOG_PROF+1)'(pop);
`ifdef ECO_MOVIMENTO_EN
            if (tx_pronto_i) eco_pend_q <= 1'b0;
            if (push && !eco_pend_q) begin
                tx_partida_q <= 1'b1;
                tx_dados_q   <= rx_dados_i;
                eco_pend_q   <= 1'b1;
            end
`endif
            case (estado_q)
                OCIOSO, FIM: begin
                    if (iniciar_i) begin
                        estado_q     <= PEDE;
                        tx_partida_q <= 1'b1;
                        tx_dados_q   <= 8'hFF;
                        fim_q        <= 1'b0;
                        erro_q       <= 1'b0;
                        wr_q         <= '0;
                        rd_q         <= '0;
                        cont_q       <= '0;
                    end
                end
                PEDE:      estado_q <= ESPERA_TX;
                ESPERA_TX: if (tx_pronto_i) estado_q <= RECEBE;
                RECEBE: begin
                    if (aceita_rx && rx_dados_i != 8'h00 && (!byte_mov || cheia)) erro_q <= 1'b1;
`ifdef ECO_MOVIMENTO_EN
                    if (aceita_rx && rx_dados_i == 8'h00) begin
                        if (eco_livre) estado_q <= EXECUTA;
                        else sai_q <= 1'b1;
                    end else if (sai_q && eco_livre) begin
                        sai_q    <= 1'b0;
                        estado_q <= EXECUTA;
                    end
`else
                    if (aceita_rx && rx_dados_i == 8'h00) estado_q <= EXECUTA;
`endif
                end
                EXECUTA: begin
                    if (vazia) begin
                        estado_q <= FIM;
                        fim_q    <= 1'b1;
                    end else begin
                        mov_codigo_q  <= mem_q[rd_q];
                        mov_partida_q <= 1'b1;
                        estado_q      <= ESPERA_MOV;
                    end
                end
                ESPERA_MOV: if (mov_fim_i) estado_q <= EXECUTA;
                default:    estado_q <= OCIOSO;
            endcase
        end
    end
endmodule

// File: tb/tb_sequenciador_movimentos.sv
// tb_sequenciador_movimentos: randomized scoreboard bench with UART and executor responders.
module tb_sequenciador_movimentos;
    localparam int PROF = 32;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1, iniciar_i = 1'b0, rx_pronto_i = 1'b0;
    logic [7:0] rx_dados_i = 8'h00;
    logic       tx_partida_o, tx_pronto_i, mov_partida_o, mov_fim_i, fim_o, erro_o;
    logic [7:0] tx_dados_o;
    logic [2:0] mov_codigo_o;
    logic [3:0] db_estado_o;

    int total = 0, bad = 0;
    int exp_tx[$];
    int exp_mov[$];
    int mov_pulses = 0;
    int kick_req = 0;
    bit hold_mov = 1'b0;
    int m_cont = 0, m_push = 0;
    bit m_erro = 1'b0;

    always #10 clk = ~clk;

    sequenciador_movimentos #(.PROFUNDIDADE(PROF), .LOG_PROF(5)) dut (
        .clock_i(clk), .reset_i(reset_i), .iniciar_i(iniciar_i),
        .rx_pronto_i(rx_pronto_i), .rx_dados_i(rx_dados_i),
        .tx_partida_o(tx_partida_o), .tx_dados_o(tx_dados_o), .tx_pronto_i(tx_pronto_i),
        .mov_partida_o(mov_partida_o), .mov_codigo_o(mov_codigo_o), .mov_fim_i(mov_fim_i),
        .fim_o(fim_o), .erro_o(erro_o), .db_estado_o(db_estado_o)
    );

    task automatic check(input string nome, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nome, got, want);
        end
    endtask

    // UART responder and TX monitor
    initial begin
        int cnt = 0;
        int dado = 0;
        tx_pronto_i = 1'b0;
        forever begin
            @(negedge clk);
            tx_pronto_i = 1'b0;
            if (reset_i) cnt = 0;
            else if (tx_partida_o) begin
                check("tx_sem_sobreposicao", cnt, 0);
                if (exp_tx.size() == 0) check("tx_inesperado", int'(tx_dados_o), -1);
                else check("tx_dados", int'(tx_dados_o), exp_tx.pop_front());
                dado = int'(tx_dados_o);
                cnt = int'($urandom_range(2, 5));
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    check("tx_dados_estavel", int'(tx_dados_o), dado);
                    tx_pronto_i = 1'b1;
                end
            end
        end
    end

    // Executor responder and move monitor
    initial begin
        int cnt = 0;
        int cod = 0;
        int kick_done = 0;
        bit pend = 1'b0;
        mov_fim_i = 1'b0;
        forever begin
            @(negedge clk);
            mov_fim_i = 1'b0;
            if (reset_i) pend = 1'b0;
            else if (mov_partida_o) begin
                mov_pulses++;
                check("mov_apos_fim_anterior", int'(pend), 0);
                if (exp_mov.size() == 0) check("mov_inesperado", int'(mov_codigo_o), -1);
                else check("mov_codigo", int'(mov_codigo_o), exp_mov.pop_front());
                pend = 1'b1;
                cod = int'(mov_codigo_o);
                cnt = int'($urandom_range(1, 6));
            end else if (pend && !hold_mov) begin
                cnt--;
                if (cnt == 0) begin
                    check("mov_codigo_estavel", int'(mov_codigo_o), cod);
                    mov_fim_i = 1'b1;
                    pend = 1'b0;
                end
            end
            if (kick_req != kick_done) begin
                kick_done++;
                mov_fim_i = 1'b1;
            end
        end
    end

    task automatic wait_estado(input int code, input int budget, input string nome);
        int k = 0;
        while (int'(db_estado_o) != code && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(nome, int'(db_estado_o), code);
    endtask

    task automatic pulse_iniciar();
        iniciar_i = 1'b1;
        @(negedge clk);
        iniciar_i = 1'b0;
    endtask

    // Reference rule: 1..7 stored while room remains, anything else non-zero flags an error.
    task automatic send_byte(input int b);
        if (b != 0) begin
            if (b < 8 && m_cont < PROF) begin
                exp_mov.push_back(b);
                m_cont++;
                m_push++;
`ifdef ECO_MOVIMENTO_EN
                exp_tx.push_back(b);
`endif
            end else m_erro = 1'b1;
        end
        rx_dados_i = 8'(b);
        rx_pronto_i = 1'b1;
        @(negedge clk);
        rx_pronto_i = 1'b0;
        rx_dados_i = 8'($urandom);
        repeat (10) @(negedge clk);
    endtask

    task automatic start_seq();
        m_cont = 0;
        m_push = 0;
        m_erro = 1'b0;
        exp_tx.push_back(8'hFF);
        pulse_iniciar();
        wait_estado(3, 60, "chega_recebe");
    endtask

    task automatic run_seq(input int lista[$], input bit ruido);
        int p0;
        int k = 0;
        p0 = mov_pulses;
        start_seq();
        foreach (lista[i]) begin
            if (ruido && $urandom_range(0, 5) == 0) pulse_iniciar();
            send_byte(lista[i]);
        end
        send_byte(0);
        while (!fim_o && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check("fim", int'(fim_o), 1);
        check("estado_fim", int'(db_estado_o), 6);
        check("erro", int'(erro_o), int'(m_erro));
        check("n_movimentos", mov_pulses - p0, m_push);
        check("fila_mov_vazia", exp_mov.size(), 0);
        check("fila_tx_vazia", exp_tx.size(), 0);
    endtask

    initial begin
        int lista[$];
        int p0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        check("rst_estado", int'(db_estado_o), 0);
        check("rst_tx_partida", int'(tx_partida_o), 0);
        check("rst_tx_dados", int'(tx_dados_o), 0);
        check("rst_mov_partida", int'(mov_partida_o), 0);
        check("rst_mov_codigo", int'(mov_codigo_o), 0);
        check("rst_fim", int'(fim_o), 0);
        check("rst_erro", int'(erro_o), 0);

        lista = '{1, 2, 3};
        run_seq(lista, 1'b0);

        rx_dados_i = 8'h03;
        rx_pronto_i = 1'b1;
        @(negedge clk);
        rx_pronto_i = 1'b0;
        lista = {};
        run_seq(lista, 1'b0);

        lista = {};
        repeat (33) lista.push_back(5);
        run_seq(lista, 1'b0);

        lista = '{2, 6, 8'h1A, 7, 1};
        run_seq(lista, 1'b1);

        repeat (6) begin
            lista = {};
            repeat ($urandom_range(0, 40))
                lista.push_back($urandom_range(0, 9) == 0 ? int'($urandom_range(8, 255)) : int'($urandom_range(1, 7)));
            run_seq(lista, 1'b1);
        end

        hold_mov = 1'b1;
        start_seq();
        send_byte(4);
        send_byte(5);
        send_byte(0);
        wait_estado(5, 100, "espera_mov_antes_reset");
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        exp_mov.delete();
        hold_mov = 1'b0;
        check("reset_estado", int'(db_estado_o), 0);
        check("reset_mov_partida", int'(mov_partida_o), 0);
        check("reset_fim", int'(fim_o), 0);
        check("reset_erro", int'(erro_o), 0);
        p0 = mov_pulses;
        kick_req++;
        repeat (6) @(negedge clk);
        check("mov_fim_ignorado_estado", int'(db_estado_o), 0);
        check("mov_fim_ignorado_pulsos", mov_pulses - p0, 0);

        lista = '{7, 3};
        run_seq(lista, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
